dmem_responder: RTL and testbench
=================================

# dmem_responder

Memory-side responder for the data memory port: it accepts requests in the core's memory request format and returns responses in the core's memory response format. It is a single-port RAM with a programmable number of wait states. It sits at the far end of the data path, after the data TIM/cache stage, and terminates the interface that stage drives. It also serves as the standalone data memory for cache-less builds and for the bench.

## Interface
Parameters:
- mem_depth, 10, log2 of RAM size in 32-bit words.
- mem_latency, 2, number of wait cycles before the response; legal range 0..15.
- mem_base, 32'h0, byte address mapped to word 0.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-low.
- dmem_in  in  mem_in_type  request fields:
  - mem_valid (1)
  - mem_fence (1)
  - mem_instr (1, ignored)
  - mem_addr (32)
  - mem_wdata (32)
  - mem_wstrb (4)
- dmem_out  out  mem_out_type  response fields:
  - mem_ready (1)
  - mem_rdata (32)
- dmem_busy  out  1  high while a request is in flight; requests are not accepted.
- dmem_err  out  1  sticky out-of-range flag (see Configuration).

## Operation
- States: IDLE, WAIT, RESP. Reset state is IDLE.
- Accept condition: mem_valid=1 while state is IDLE or RESP. On accept:
  - addr, wdata, wstrb and fence are registered.
  - The cycle counter loads mem_latency.
  - Next state is WAIT if mem_latency>0, otherwise RESP.
- WAIT: the counter decrements each cycle. When the counter reaches 1, next state is RESP.
- RESP: the RAM access is performed and mem_ready=1 for exactly one cycle. Next state is IDLE, or WAIT/RESP if a new request is accepted in this same cycle (back-to-back).
- Word index = ((mem_addr - mem_base) >> 2)[mem_depth-1:0]. Address bits [1:0] are ignored.
- Access type:
  - Read: wstrb=4'b0000. mem_rdata returns the full word.
  - Write: wstrb≠0. Only the bytes whose strobe bit is 1 are updated, with lane i = wdata[8i+7:8i]. mem_rdata=0.
  - Fence: fence=1. Acknowledged with mem_ready, no RAM access, mem_rdata=0. Fence takes priority over wstrb.
- Requests arriving in WAIT are dropped. No queueing. dmem_busy=1 in WAIT, so the initiator holds off.
- RAM contents are not initialised or cleared by reset.

## Timing
- Request accepted at edge T: mem_ready=1 during the cycle after edge T+1+mem_latency. With mem_latency=0, ready is high in the cycle immediately following acceptance.
- mem_rdata is valid only while mem_ready=1 and is 0 otherwise. Both are driven from registers.
- Back-to-back throughput is one request per 1+mem_latency cycles.
- Reset values:
  - mem_ready=0
  - mem_rdata=0
  - dmem_busy=0
  - dmem_err=0
  - state=IDLE
  - counter=0
- Reset asserted mid-request: the request is abandoned, no write is committed, and no mem_ready is produced.
- A read following a write to the same word returns the written data, because the write commits in its RESP cycle, which precedes the read.

## Configuration
- DMEM_RESP_BOUNDS_EN defined:
  - The byte offset (mem_addr - mem_base) is checked against 4·2^mem_depth. An offset ≥ 4·2^mem_depth, or an address below mem_base, is out of range.
  - An out-of-range access still completes with normal timing. Reads return 0, and writes are discarded.
  - dmem_err is set in the RESP cycle and held until reset.
- DMEM_RESP_BOUNDS_EN undefined:
  - There is no check, and the index wraps modulo 2^mem_depth.
  - dmem_err is tied to 0.

## Test plan
- Latency: mem_latency=2. Write 0xDEADBEEF to 0x10 with wstrb=4'hF, then read 0x10.
  - Each mem_ready arrives exactly 3 cycles after acceptance.
  - The read returns 0xDEADBEEF.
- Byte strobes: word 0x20 holds 0x11223344. Write 0xAABBCCDD with wstrb=4'b0101, then read 0x20.
  - The read returns 0x11BB33DD.
- Fence and drop:
  - A fence request returns ready with rdata=0, and memory is unchanged.
  - A valid request issued during WAIT produces no response and no write; dmem_busy=1 in those cycles.
- Zero latency: mem_latency=0. Issue four back-to-back reads in consecutive cycles.
  - Four consecutive mem_ready pulses, each one cycle after its request, with the correct data.
- Reset mid-request: mem_latency=3. Write 0x5 to 0x40, and assert rst in the second WAIT cycle.
  - No mem_ready is produced.
  - All outputs read 0.
  - A subsequent read of 0x40 returns the pre-write value.
- Bounds: mem_depth=4 and DMEM_RESP_BOUNDS_EN defined. Read 0x40.
  - Returns 0, and dmem_err=1 from then on.
  - Without the macro, the same read returns word 0.

Source files
------------

// File: rtl/dmem_responder_if.sv
// Request/response bundle between the data path (master) and the data memory responder (slave).
interface dmem_responder_if;
  logic        mem_valid;
  logic        mem_fence;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_fence, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_fence, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/dmem_responder.sv
// Single-port data RAM with a programmable number of wait states, terminating the core data memory port.
// Define DMEM_RESP_BOUNDS_EN to enable out-of-range detection with a sticky dmem_err flag.
module dmem_responder #(
  parameter int          mem_depth   = 10,
  parameter int          mem_latency = 2,
  parameter logic [31:0] mem_base    = 32'h0
) (
  input  logic            clk,
  input  logic            rst,
  dmem_responder_if.slave dmem,
  output logic            dmem_busy,
  output logic            dmem_err
);
  localparam int         WORDS = 1 << mem_depth;
  localparam logic [3:0] LAT   = 4'(mem_latency);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [3:0]             cnt_r;
  logic [3:0]             cnt_nxt_s;
  logic                   accept_s;

  logic [31:0]            addr_r;
  logic [31:0]            wdata_r;
  logic [3:0]             wstrb_r;
  logic                   fence_r;

  logic                   ready_r;
  logic [31:0]            rdata_r;
  logic                   busy_r;
  logic                   err_r;

  logic [31:0]            off_s;
  logic [mem_depth-1:0]   idx_s;
  logic                   oob_s;
  logic                   ram_we_s;
  logic [31:0]            resp_rdata_s;
  logic                   unused_s;

  logic [31:0]            ram_r [WORDS];

  assign off_s = addr_r - mem_base;
  assign idx_s = off_s[mem_depth+1:2];

`ifdef DMEM_RESP_BOUNDS_EN
  localparam logic [32:0] SPAN = 33'd4 << mem_depth;
  assign oob_s = (addr_r < mem_base) || ({1'b0, off_s} >= SPAN);
`else
  assign oob_s = 1'b0;
`endif

  // Instruction flag and sub-word/overflow offset bits carry no meaning for a data RAM.
  assign unused_s = ^{dmem.mem_instr, off_s[31:mem_depth+2], off_s[1:0]};

  // Next-state and counter logic; a request is taken in IDLE or in RESP (back-to-back).
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    accept_s    = 1'b0;
    case (state_r)
      IDLE, RESP: begin
        if (dmem.mem_valid) begin
          accept_s  = 1'b1;
          cnt_nxt_s = LAT;
          if (LAT != 4'd0) begin
            state_nxt_s = WAIT;
          end else begin
            state_nxt_s = RESP;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT: begin
        cnt_nxt_s = cnt_r - 4'd1;
        if (cnt_r <= 4'd1) begin
          state_nxt_s = RESP;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = 4'd0;
      end
    endcase
  end

  // Response data: only plain in-range reads return RAM contents.
  always_comb begin
    resp_rdata_s = 32'd0;
    if ((state_r == RESP) && !fence_r && (wstrb_r == 4'd0) && !oob_s) begin
      resp_rdata_s = ram_r[idx_s];
    end else begin
      resp_rdata_s = 32'd0;
    end
  end

  assign ram_we_s = (state_r == RESP) && !fence_r && (wstrb_r != 4'd0) && !oob_s;

  // FSM state, wait counter and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      ready_r <= 1'b0;
      rdata_r <= 32'd0;
      busy_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      ready_r <= (state_r == RESP);
      rdata_r <= resp_rdata_s;
      busy_r  <= (state_nxt_s == WAIT);
      if ((state_r == RESP) && oob_s) begin
        err_r <= 1'b1;
      end
    end
  end

  // Request capture on accept.
  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_r  <= 32'd0;
      wdata_r <= 32'd0;
      wstrb_r <= 4'd0;
      fence_r <= 1'b0;
    end else if (accept_s) begin
      addr_r  <= dmem.mem_addr;
      wdata_r <= dmem.mem_wdata;
      wstrb_r <= dmem.mem_wstrb;
      fence_r <= dmem.mem_fence;
    end
  end

  // Byte-lane RAM write; a reset in the RESP cycle abandons the commit.
  always_ff @(posedge clk) begin
    if (rst && ram_we_s) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_r[i]) begin
          ram_r[idx_s][8*i +: 8] <= wdata_r[8*i +: 8];
        end
      end
    end
  end

  assign dmem.mem_ready = ready_r;
  assign dmem.mem_rdata = rdata_r;
  assign dmem_busy      = busy_r;
  assign dmem_err       = err_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: four instances with different latency/depth settings.
module tb_dmem_responder;
  typedef struct {
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : (k == 1) ? 0 : (k == 2) ? 3 : 1;
  endfunction

  function automatic int dep_of(input int k);
    return (k == 3) ? 4 : 10;
  endfunction

`ifdef DMEM_RESP_BOUNDS_EN
  localparam logic [31:0] OOB_RD  = 32'h0;
  localparam logic [31:0] OOB_ERR = 32'h1;
`else
  localparam logic [31:0] OOB_RD  = 32'hCAFE0001;
  localparam logic [31:0] OOB_ERR = 32'h0;
`endif

  logic        clk = 1'b0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  logic        rst_v   [4];
  logic        valid   [4];
  logic        fence   [4];
  logic [31:0] addr    [4];
  logic [31:0] wdata   [4];
  logic [3:0]  wstrb   [4];
  logic        rdy     [4];
  logic [31:0] rd      [4];
  logic        bsy     [4];
  logic        er      [4];

  exp_t        exp_q   [4][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  for (genvar k = 0; k < 4; k++) begin : g_dut
    dmem_responder_if bus ();
    logic busy_s;
    logic err_s;
    exp_t e;

    assign bus.mem_valid = valid[k];
    assign bus.mem_fence = fence[k];
    assign bus.mem_instr = 1'b0;
    assign bus.mem_addr  = addr[k];
    assign bus.mem_wdata = wdata[k];
    assign bus.mem_wstrb = wstrb[k];

    dmem_responder #(
      .mem_depth  (dep_of(k)),
      .mem_latency(lat_of(k)),
      .mem_base   (32'h0)
    ) u_dut (
      .clk      (clk),
      .rst      (rst_v[k]),
      .dmem     (bus),
      .dmem_busy(busy_s),
      .dmem_err (err_s)
    );

    assign rdy[k] = bus.mem_ready;
    assign rd[k]  = bus.mem_rdata;
    assign bsy[k] = busy_s;
    assign er[k]  = err_s;

    // Monitor: every ready pulse must match the oldest expected response.
    always @(negedge clk) begin
      if (bus.mem_ready === 1'b1) begin
        if (exp_q[k].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ready dut%0d: got ready=1 rdata=%h expected no response", k, bus.mem_rdata);
        end else begin
          e = exp_q[k].pop_front();
          check($sformatf("rdata dut%0d", k), bus.mem_rdata, e.rdata);
          check($sformatf("ready_cycle dut%0d", k), 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  task automatic issue(input int k, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic f, input logic [31:0] exp_rd,
                       input bit track);
    exp_t e;
    valid[k] = 1'b1;
    addr[k]  = a;
    wdata[k] = d;
    wstrb[k] = s;
    fence[k] = f;
    if (track) begin
      e.rdata = exp_rd;
      e.cyc   = cyc + 2 + lat_of(k);
      exp_q[k].push_back(e);
    end
    @(posedge clk); #1;
    valid[k] = 1'b0;
  endtask

  task automatic wait_drain(input int k);
    int n;
    n = 0;
    while (exp_q[k].size() != 0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q[k].size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout dut%0d: got %0d pending expected 0", k, exp_q[k].size());
      exp_q[k].delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      rst_v[i] = 1'b0;
      valid[i] = 1'b0;
      fence[i] = 1'b0;
      addr[i]  = 32'h0;
      wdata[i] = 32'h0;
      wstrb[i] = 4'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst_ready dut%0d", i), 32'(rdy[i]), 32'h0);
      check($sformatf("rst_rdata dut%0d", i), rd[i], 32'h0);
      check($sformatf("rst_busy dut%0d", i), 32'(bsy[i]), 32'h0);
      check($sformatf("rst_err dut%0d", i), 32'(er[i]), 32'h0);
    end
    for (int i = 0; i < 4; i++) rst_v[i] = 1'b1;
    @(posedge clk); #1;

    // Latency 2: write then read back
    issue(0, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0, 1'b1);
    wait_drain(0);
    issue(0, 32'h10, 32'h0, 4'h0, 1'b0, 32'hDEADBEEF, 1'b1);
    wait_drain(0);

    // Byte strobes
    issue(0, 32'h20, 32'h11223344, 4'hF, 1'b0, 32'h0, 1'b1);
    wait_drain(0);
    issue(0, 32'h20, 32'hAABBCCDD, 4'b0101, 1'b0, 32'h0, 1'b1);
    wait_drain(0);
    issue(0, 32'h20, 32'h0, 4'h0, 1'b0, 32'h11BB33DD, 1'b1);
    wait_drain(0);

    // Fence with write strobes set must not touch memory
    issue(0, 32'h10, 32'hFFFFFFFF, 4'hF, 1'b1, 32'h0, 1'b1);
    wait_drain(0);
    issue(0, 32'h10, 32'h0, 4'h0, 1'b0, 32'hDEADBEEF, 1'b1);
    wait_drain(0);

    // Request during WAIT is dropped
    issue(0, 32'h30, 32'h12345678, 4'hF, 1'b0, 32'h0, 1'b1);
    valid[0] = 1'b1;
    addr[0]  = 32'h20;
    wdata[0] = 32'hFFFFFFFF;
    wstrb[0] = 4'hF;
    fence[0] = 1'b0;
    check("busy_wait1", 32'(bsy[0]), 32'h1);
    @(posedge clk); #1;
    check("busy_wait2", 32'(bsy[0]), 32'h1);
    @(posedge clk); #1;
    valid[0] = 1'b0;
    wait_drain(0);
    check("busy_idle", 32'(bsy[0]), 32'h0);
    issue(0, 32'h20, 32'h0, 4'h0, 1'b0, 32'h11BB33DD, 1'b1);
    wait_drain(0);
    issue(0, 32'h30, 32'h0, 4'h0, 1'b0, 32'h12345678, 1'b1);
    wait_drain(0);

    // Zero latency: back-to-back writes then back-to-back reads
    issue(1, 32'h0, 32'h0A0A0A0A, 4'hF, 1'b0, 32'h0, 1'b1);
    issue(1, 32'h4, 32'h1B1B1B1B, 4'hF, 1'b0, 32'h0, 1'b1);
    issue(1, 32'h8, 32'h2C2C2C2C, 4'hF, 1'b0, 32'h0, 1'b1);
    issue(1, 32'hC, 32'h3D3D3D3D, 4'hF, 1'b0, 32'h0, 1'b1);
    wait_drain(1);
    issue(1, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0A0A0A0A, 1'b1);
    issue(1, 32'h4, 32'h0, 4'h0, 1'b0, 32'h1B1B1B1B, 1'b1);
    issue(1, 32'h8, 32'h0, 4'h0, 1'b0, 32'h2C2C2C2C, 1'b1);
    issue(1, 32'hC, 32'h0, 4'h0, 1'b0, 32'h3D3D3D3D, 1'b1);
    wait_drain(1);

    // Reset in the second WAIT cycle abandons the write
    issue(2, 32'h40, 32'h000000AA, 4'hF, 1'b0, 32'h0, 1'b1);
    wait_drain(2);
    issue(2, 32'h40, 32'h00000005, 4'hF, 1'b0, 32'h0, 1'b0);
    @(posedge clk); #1;
    rst_v[2] = 1'b0;
    @(posedge clk); #1;
    check("midrst_ready", 32'(rdy[2]), 32'h0);
    check("midrst_rdata", rd[2], 32'h0);
    check("midrst_busy", 32'(bsy[2]), 32'h0);
    check("midrst_err", 32'(er[2]), 32'h0);
    @(posedge clk); #1;
    rst_v[2] = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    issue(2, 32'h40, 32'h0, 4'h0, 1'b0, 32'h000000AA, 1'b1);
    wait_drain(2);

    // Bounds: depth 4 -> 0x40 is one past the end
    issue(3, 32'h0, 32'hCAFE0001, 4'hF, 1'b0, 32'h0, 1'b1);
    wait_drain(3);
    check("err_before", 32'(er[3]), 32'h0);
    issue(3, 32'h40, 32'h0, 4'h0, 1'b0, OOB_RD, 1'b1);
    wait_drain(3);
    check("err_after", 32'(er[3]), OOB_ERR);
    issue(3, 32'h0, 32'h0, 4'h0, 1'b0, 32'hCAFE0001, 1'b1);
    wait_drain(3);
    check("err_sticky", 32'(er[3]), OOB_ERR);

    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("queue_empty dut%0d", i), 32'(exp_q[i].size()), 32'h0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
